// File: rtl/pll_lock_supervisor_if.sv
// Bundle of supervisor-to-PLL-wrapper signals (clr, raw lock in, reset/status out).
// Latency: wires only; no state.
// Backpressure: none; every signal is a level or a single-cycle pulse.
//
// Ports grouped here:
//   clr         restart/clear pulse into the supervisor
//   pll_lock    raw lock per PLL (asynchronous to clk)
//   pll_rst     active-high reset per PLL
//   pll_locked  qualified lock per PLL
//   all_locked  registered AND of pll_locked
//   pll_fail    sticky failure per PLL
//   lock_evt    one-cycle pulse when pll_locked rises
//   loss_cnt    saturating lock-loss counts, channel i at [i*CNT_W +: CNT_W]
interface pll_lock_supervisor_if #(
   parameter int NUM_PLL = 2,
   parameter int CNT_W   = 8
);
   logic                     clr;
   logic [NUM_PLL-1:0]       pll_lock;
   logic [NUM_PLL-1:0]       pll_rst;
   logic [NUM_PLL-1:0]       pll_locked;
   logic                     all_locked;
   logic [NUM_PLL-1:0]       pll_fail;
   logic [NUM_PLL-1:0]       lock_evt;
   logic [NUM_PLL*CNT_W-1:0] loss_cnt;

   // Supervisor side.
   modport master (
      input  clr,
      input  pll_lock,
      output pll_rst,
      output pll_locked,
      output all_locked,
      output pll_fail,
      output lock_evt,
      output loss_cnt
   );

   // Controller / PLL-wrapper side.
   modport slave (
      output clr,
      output pll_lock,
      input  pll_rst,
      input  pll_locked,
      input  all_locked,
      input  pll_fail,
      input  lock_evt,
      input  loss_cnt
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Per-PLL reset sequencer and lock qualifier with retry, loss counting and failure flag.
// Latency: lock rise -> pll_locked SYNC_STAGES+STABLE_CYCLES+1; lock fall -> drop SYNC_STAGES+1.
// Backpressure: none; outputs are decoded from per-channel state every cycle.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (all channels back to RST, pll_rst high)
//   bus    pll_lock_supervisor_if.master: clr, pll_lock in; pll_rst, pll_locked,
//          all_locked, pll_fail, lock_evt, loss_cnt out
module pll_lock_supervisor #(
   parameter int NUM_PLL       = 2,
   parameter int SYNC_STAGES   = 2,
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 4096,
   parameter int STABLE_CYCLES = 64,
   parameter int MAX_RETRY     = 3,
   parameter int AUTO_RELOCK   = 1,
   parameter int CNT_W         = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   pll_lock_supervisor_if.master        bus
);

   // ptmr is shared by the RST hold and the STABLE window, so it is sized for the larger.
   localparam int PTMR_MAX = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
   localparam int PTMR_W   = (PTMR_MAX > 1) ? $clog2(PTMR_MAX) : 1;
   localparam int WTMR_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam int RETRY_W  = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

   localparam logic [PTMR_W-1:0]  RST_LAST    = PTMR_W'(RST_CYCLES - 1);
   localparam logic [PTMR_W-1:0]  STABLE_LAST = PTMR_W'(STABLE_CYCLES - 1);
   localparam logic [WTMR_W-1:0]  WTMR_LAST   = WTMR_W'(LOCK_TIMEOUT - 1);
   // retry_cnt+1 == MAX_RETRY is tested as retry_cnt == MAX_RETRY-1 so the count never overflows.
   localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY - 1);
   localparam logic [CNT_W-1:0]   LOSS_MAX    = '1;

   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_WAIT   = 3'd1,
      ST_STABLE = 3'd2,
      ST_LOCKED = 3'd3,
      ST_FAIL   = 3'd4
   } state_e;

   state_e               state_q [NUM_PLL];
   state_e               state_d [NUM_PLL];
   logic [SYNC_STAGES-1:0] sync_q [NUM_PLL];
   logic [SYNC_STAGES-1:0] sync_d [NUM_PLL];
   logic [PTMR_W-1:0]    ptmr_q  [NUM_PLL];
   logic [PTMR_W-1:0]    ptmr_d  [NUM_PLL];
   logic [WTMR_W-1:0]    wtmr_q  [NUM_PLL];
   logic [WTMR_W-1:0]    wtmr_d  [NUM_PLL];
   logic [RETRY_W-1:0]   retry_q [NUM_PLL];
   logic [RETRY_W-1:0]   retry_d [NUM_PLL];
   logic [CNT_W-1:0]     loss_q  [NUM_PLL];
   logic [CNT_W-1:0]     loss_d  [NUM_PLL];
   logic [NUM_PLL-1:0]   lock_evt_q, lock_evt_d;
   logic                 all_locked_q, all_locked_d;

   logic [NUM_PLL-1:0]   lock_s;
   logic [NUM_PLL-1:0]   pll_rst_o, pll_locked_o, pll_fail_o;
   logic [NUM_PLL*CNT_W-1:0] loss_cnt_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PLL; i++) begin
            state_q[i] <= ST_RST;
            sync_q[i]  <= '0;
            ptmr_q[i]  <= '0;
            wtmr_q[i]  <= '0;
            retry_q[i] <= '0;
            loss_q[i]  <= '0;
         end
         lock_evt_q   <= '0;
         all_locked_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PLL; i++) begin
            state_q[i] <= state_d[i];
            sync_q[i]  <= sync_d[i];
            ptmr_q[i]  <= ptmr_d[i];
            wtmr_q[i]  <= wtmr_d[i];
            retry_q[i] <= retry_d[i];
            loss_q[i]  <= loss_d[i];
         end
         lock_evt_q   <= lock_evt_d;
         all_locked_q <= all_locked_d;
      end
   end

   // Output decode and synchronised lock taps.
   always_comb begin
      lock_s       = '0;
      pll_rst_o    = '0;
      pll_locked_o = '0;
      pll_fail_o   = '0;
      loss_cnt_o   = '0;
      for (int i = 0; i < NUM_PLL; i++) begin
         lock_s[i]       = sync_q[i][SYNC_STAGES-1];
         pll_rst_o[i]    = (state_q[i] == ST_RST) || (state_q[i] == ST_FAIL);
         pll_locked_o[i] = (state_q[i] == ST_LOCKED);
         pll_fail_o[i]   = (state_q[i] == ST_FAIL);
         loss_cnt_o[i*CNT_W +: CNT_W] = loss_q[i];
      end
   end

   always_comb begin
      all_locked_d = &pll_locked_o;
      lock_evt_d   = '0;
      for (int i = 0; i < NUM_PLL; i++) begin
         state_d[i] = state_q[i];
         sync_d[i]  = {sync_q[i][SYNC_STAGES-2:0], bus.pll_lock[i]};
         ptmr_d[i]  = ptmr_q[i];
         wtmr_d[i]  = wtmr_q[i];
         retry_d[i] = retry_q[i];
         loss_d[i]  = loss_q[i];

         case (state_q[i])
            ST_RST: begin
               if (ptmr_q[i] == RST_LAST) begin
                  state_d[i] = ST_WAIT;
                  ptmr_d[i]  = '0;
                  wtmr_d[i]  = '0;
               end else begin
                  ptmr_d[i] = ptmr_q[i] + 1'b1;
               end
            end
            ST_WAIT, ST_STABLE: begin
               // The window timer runs across WAIT<->STABLE bounces, so a chattering
               // lock still hits the timeout; the timeout beats any lock transition.
               if (wtmr_q[i] == WTMR_LAST) begin
                  if (retry_q[i] == RETRY_LAST) begin
                     state_d[i] = ST_FAIL;
                  end else begin
                     retry_d[i] = retry_q[i] + 1'b1;
                     state_d[i] = ST_RST;
                     ptmr_d[i]  = '0;
                  end
               end else begin
                  wtmr_d[i] = wtmr_q[i] + 1'b1;
                  if (state_q[i] == ST_WAIT) begin
                     if (lock_s[i]) begin
                        state_d[i] = ST_STABLE;
                        ptmr_d[i]  = '0;
                     end
                  end else if (!lock_s[i]) begin
                     state_d[i] = ST_WAIT;
                  end else if (ptmr_q[i] == STABLE_LAST) begin
                     state_d[i] = ST_LOCKED;
                     retry_d[i] = '0;
                  end else begin
                     ptmr_d[i] = ptmr_q[i] + 1'b1;
                  end
               end
            end
            ST_LOCKED: begin
               retry_d[i] = '0;
               if (!lock_s[i]) begin
                  if (loss_q[i] != LOSS_MAX) begin
                     loss_d[i] = loss_q[i] + 1'b1;
                  end
                  state_d[i] = (AUTO_RELOCK != 0) ? ST_RST : ST_FAIL;
                  ptmr_d[i]  = '0;
               end
            end
            ST_FAIL: begin
               state_d[i] = ST_FAIL;
            end
            default: begin
               state_d[i] = ST_RST;
               ptmr_d[i]  = '0;
            end
         endcase

         lock_evt_d[i] = (state_d[i] == ST_LOCKED) && (state_q[i] != ST_LOCKED);

         // clr overrides everything above, including a loss seen in the same cycle.
         if (bus.clr) begin
            state_d[i]    = ST_RST;
            ptmr_d[i]     = '0;
            wtmr_d[i]     = '0;
            retry_d[i]    = '0;
            loss_d[i]     = '0;
            lock_evt_d[i] = 1'b0;
         end
      end
   end

   assign bus.pll_rst    = pll_rst_o;
   assign bus.pll_locked = pll_locked_o;
   assign bus.pll_fail   = pll_fail_o;
   assign bus.loss_cnt   = loss_cnt_o;
   assign bus.lock_evt   = lock_evt_q;
   assign bus.all_locked = all_locked_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: bring-up, chatter/timeout, loss/relock,
// clr recovery, mid-run reset, and a no-relock build sharing clock and reset.
module tb_pll_lock_supervisor;

   logic clk;
   logic rst_n;
   int   total;
   int   passed;

   pll_lock_supervisor_if #(.NUM_PLL(2), .CNT_W(2)) bus ();
   pll_lock_supervisor_if #(.NUM_PLL(2), .CNT_W(2)) bus_nr ();

   pll_lock_supervisor #(
      .NUM_PLL(2), .SYNC_STAGES(2), .RST_CYCLES(4), .LOCK_TIMEOUT(32),
      .STABLE_CYCLES(8), .MAX_RETRY(2), .AUTO_RELOCK(1), .CNT_W(2)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   pll_lock_supervisor #(
      .NUM_PLL(2), .SYNC_STAGES(2), .RST_CYCLES(4), .LOCK_TIMEOUT(32),
      .STABLE_CYCLES(8), .MAX_RETRY(2), .AUTO_RELOCK(0), .CNT_W(2)
   ) u_dut_nr (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_nr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.clr = 1'b0;    bus.pll_lock = 2'b00;
      bus_nr.clr = 1'b0; bus_nr.pll_lock = 2'b00;
      tick(); tick();
      total++; if (bus.pll_rst !== 2'b11) $display("FAIL reset_pll_rst: got %b want 11", bus.pll_rst); else passed++;
      total++; if (bus.pll_locked !== 2'b00) $display("FAIL reset_pll_locked: got %b want 00", bus.pll_locked); else passed++;
      total++; if (bus.all_locked !== 1'b0) $display("FAIL reset_all_locked: got %b want 0", bus.all_locked); else passed++;
      total++; if (bus.pll_fail !== 2'b00) $display("FAIL reset_pll_fail: got %b want 00", bus.pll_fail); else passed++;
      total++; if (bus.lock_evt !== 2'b00) $display("FAIL reset_lock_evt: got %b want 00", bus.lock_evt); else passed++;
      total++; if (bus.loss_cnt !== 4'h0) $display("FAIL reset_loss_cnt: got %h want 0", bus.loss_cnt); else passed++;
      total++; if (bus_nr.pll_rst !== 2'b11) $display("FAIL reset_nr_pll_rst: got %b want 11", bus_nr.pll_rst); else passed++;
   endtask

   task automatic test_nominal();
      int n;
      int f_l0, f_e0, e0_cnt, f_l1, f_al;
      rst_n = 1'b1;
      n = 0;
      while (bus.pll_rst[0] === 1'b1 && n < 100) begin n++; tick(); end
      total++; if (n != 4) $display("FAIL nominal_rst_len: got %0d cycles want 4", n); else passed++;
      repeat (10) tick();
      bus.pll_lock[0] = 1'b1;
      f_l0 = -1; f_e0 = -1; e0_cnt = 0; f_l1 = -1; f_al = -1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (bus.pll_locked[0] === 1'b1 && f_l0 < 0) f_l0 = k;
         if (bus.lock_evt[0] === 1'b1) begin e0_cnt++; if (f_e0 < 0) f_e0 = k; end
         if (bus.pll_locked[1] === 1'b1 && f_l1 < 0) f_l1 = k;
         if (bus.all_locked === 1'b1 && f_al < 0) f_al = k;
         if (k == 2) bus.pll_lock[1] = 1'b1;
      end
      total++; if (f_l0 != 11) $display("FAIL nominal_lock0_latency: got %0d want 11", f_l0); else passed++;
      total++; if (e0_cnt != 1) $display("FAIL nominal_evt0_count: got %0d want 1", e0_cnt); else passed++;
      total++; if (f_e0 != 11) $display("FAIL nominal_evt0_cycle: got %0d want 11", f_e0); else passed++;
      total++; if (f_l1 != 13) $display("FAIL nominal_lock1_latency: got %0d want 13", f_l1); else passed++;
      total++; if (f_al != 14) $display("FAIL nominal_all_locked: got %0d want 14", f_al); else passed++;
   endtask

   task automatic test_lock_loss();
      int f_fall, f_rst, f_re, rst_hi, evt;
      logic [1:0] loss_v;
      logic [1:0] loss_exp;
      logic l1_drop;
      for (int k = 1; k <= 4; k++) begin
         loss_exp = (k < 3) ? 2'(k) : 2'd3;
         bus.pll_lock[0] = 1'b0;
         f_fall = -1; f_rst = -1; f_re = -1; rst_hi = 0; evt = 0; l1_drop = 1'b0; loss_v = 2'bxx;
         for (int n = 1; n <= 40; n++) begin
            tick();
            if (bus.pll_locked[0] !== 1'b1 && f_fall < 0) begin f_fall = n; loss_v = bus.loss_cnt[1:0]; end
            if (bus.pll_rst[0] === 1'b1) begin rst_hi++; if (f_rst < 0) f_rst = n; end
            if (f_fall > 0 && bus.pll_locked[0] === 1'b1 && f_re < 0) f_re = n;
            if (bus.lock_evt[0] === 1'b1) evt++;
            if (bus.pll_locked[1] !== 1'b1) l1_drop = 1'b1;
            if (n == 20) bus.pll_lock[0] = 1'b1;
         end
         total++; if (f_fall != 3) $display("FAIL loss%0d_fall: got %0d want 3", k, f_fall); else passed++;
         total++; if (loss_v !== loss_exp) $display("FAIL loss%0d_cnt: got %0d want %0d", k, loss_v, loss_exp); else passed++;
         total++; if (rst_hi != 4) $display("FAIL loss%0d_rst_len: got %0d want 4", k, rst_hi); else passed++;
         total++; if (f_rst != 3) $display("FAIL loss%0d_rst_start: got %0d want 3", k, f_rst); else passed++;
         total++; if (f_re != 31) $display("FAIL loss%0d_relock: got %0d want 31", k, f_re); else passed++;
         total++; if (evt != 1) $display("FAIL loss%0d_evt: got %0d want 1", k, evt); else passed++;
         total++; if (l1_drop !== 1'b0) $display("FAIL loss%0d_ch1_disturbed: got %b want 0", k, l1_drop); else passed++;
      end
   endtask

   task automatic test_chatter();
      logic rst_h [86];
      int f_fall, lk_cnt, rst_cnt, f_fail;
      bus.pll_lock[1] = 1'b0;
      f_fall = -1; lk_cnt = 0; rst_cnt = 0; f_fail = -1;
      for (int n = 0; n < 86; n++) rst_h[n] = 1'b0;
      for (int n = 1; n <= 85; n++) begin
         tick();
         rst_h[n] = bus.pll_rst[1];
         if (bus.pll_locked[1] !== 1'b1 && f_fall < 0) f_fall = n;
         if (n >= 4 && bus.pll_locked[1] === 1'b1) lk_cnt++;
         if (n >= 7 && n <= 74 && bus.pll_rst[1] === 1'b1) rst_cnt++;
         if (bus.pll_fail[1] === 1'b1 && f_fail < 0) f_fail = n;
         if (n % 5 == 0) bus.pll_lock[1] = ~bus.pll_lock[1];
      end
      total++; if (f_fall != 3) $display("FAIL chatter_fall: got %0d want 3", f_fall); else passed++;
      total++; if (lk_cnt != 0) $display("FAIL chatter_never_locked: got %0d locked cycles want 0", lk_cnt); else passed++;
      total++; if ({rst_h[38], rst_h[39]} !== 2'b01) $display("FAIL chatter_timeout1: got %b want 01", {rst_h[38], rst_h[39]}); else passed++;
      total++; if ({rst_h[42], rst_h[43]} !== 2'b10) $display("FAIL chatter_retry_end: got %b want 10", {rst_h[42], rst_h[43]}); else passed++;
      total++; if (rst_cnt != 4) $display("FAIL chatter_retry_len: got %0d want 4", rst_cnt); else passed++;
      total++; if (f_fail != 75) $display("FAIL chatter_fail_cycle: got %0d want 75", f_fail); else passed++;
      total++; if (bus.pll_rst[1] !== 1'b1) $display("FAIL chatter_fail_rst: got %b want 1", bus.pll_rst[1]); else passed++;
      total++; if (bus.loss_cnt[3:2] !== 2'd1) $display("FAIL chatter_loss1: got %0d want 1", bus.loss_cnt[3:2]); else passed++;
      total++; if (bus.pll_locked[0] !== 1'b1) $display("FAIL chatter_ch0_locked: got %b want 1", bus.pll_locked[0]); else passed++;
      total++; if (bus.loss_cnt[1:0] !== 2'd3) $display("FAIL chatter_loss0: got %0d want 3", bus.loss_cnt[1:0]); else passed++;
   endtask

   task automatic test_clr();
      int f_both, f_rel;
      bus.clr = 1'b1;
      bus.pll_lock[1] = 1'b1;
      tick();
      bus.clr = 1'b0;
      total++; if (bus.pll_fail !== 2'b00) $display("FAIL clr_fail: got %b want 00", bus.pll_fail); else passed++;
      total++; if (bus.loss_cnt !== 4'h0) $display("FAIL clr_loss: got %h want 0", bus.loss_cnt); else passed++;
      total++; if (bus.pll_rst !== 2'b11) $display("FAIL clr_rst: got %b want 11", bus.pll_rst); else passed++;
      total++; if (bus.pll_locked !== 2'b00) $display("FAIL clr_locked: got %b want 00", bus.pll_locked); else passed++;
      f_both = -1; f_rel = -1;
      for (int n = 2; n <= 20; n++) begin
         tick();
         if (bus.pll_locked === 2'b11 && f_both < 0) f_both = n;
         if (bus.pll_rst === 2'b00 && f_rel < 0) f_rel = n;
      end
      total++; if (f_rel != 5) $display("FAIL clr_rst_release: got %0d want 5", f_rel); else passed++;
      total++; if (f_both != 14) $display("FAIL clr_relock: got %0d want 14", f_both); else passed++;
      // clr lands on the same edge the lock drop is acted on: no loss recorded.
      bus.pll_lock[0] = 1'b0;
      tick(); tick();
      bus.clr = 1'b1;
      tick();
      total++; if (bus.loss_cnt !== 4'h0) $display("FAIL clr_coincident_loss: got %h want 0", bus.loss_cnt); else passed++;
      total++; if (bus.pll_rst !== 2'b11) $display("FAIL clr_coincident_rst: got %b want 11", bus.pll_rst); else passed++;
      repeat (10) tick();
      total++; if (bus.pll_rst !== 2'b11) $display("FAIL clr_held_rst: got %b want 11", bus.pll_rst); else passed++;
      total++; if (bus.pll_locked !== 2'b00) $display("FAIL clr_held_locked: got %b want 00", bus.pll_locked); else passed++;
   endtask

   task automatic test_reset_mid();
      int n;
      bus.clr = 1'b0;
      bus.pll_lock[0] = 1'b1;
      repeat (8) tick();
      total++; if ({bus.pll_rst[0], bus.pll_locked[0]} !== 2'b00) $display("FAIL mid_pre_stable: got %b want 00", {bus.pll_rst[0], bus.pll_locked[0]}); else passed++;
      rst_n = 1'b0;
      #1;
      total++; if (bus.pll_rst !== 2'b11) $display("FAIL mid_rst: got %b want 11", bus.pll_rst); else passed++;
      total++; if (bus.pll_locked !== 2'b00) $display("FAIL mid_locked: got %b want 00", bus.pll_locked); else passed++;
      total++; if (bus.lock_evt !== 2'b00 || bus.all_locked !== 1'b0) $display("FAIL mid_evt_all: got %b/%b want 00/0", bus.lock_evt, bus.all_locked); else passed++;
      tick();
      rst_n = 1'b1;
      n = 0;
      while (bus.pll_rst[0] === 1'b1 && n < 100) begin n++; tick(); end
      total++; if (n != 4) $display("FAIL mid_rst_len: got %0d want 4", n); else passed++;
      while (bus.pll_locked[0] !== 1'b1 && n < 40) begin tick(); n++; end
      total++; if (n != 13) $display("FAIL mid_relock: got %0d want 13", n); else passed++;
   endtask

   task automatic test_no_relock();
      int f_lk, f_fail, rst_low, fail_low, lk0;
      logic [1:0] loss_v;
      bus_nr.pll_lock = 2'b11;
      bus_nr.clr = 1'b1;
      tick();
      bus_nr.clr = 1'b0;
      f_lk = -1;
      for (int n = 2; n <= 20; n++) begin
         tick();
         if (bus_nr.pll_locked === 2'b11 && f_lk < 0) f_lk = n;
      end
      total++; if (f_lk != 14) $display("FAIL nr_lock: got %0d want 14", f_lk); else passed++;
      bus_nr.pll_lock[0] = 1'b0;
      f_fail = -1; rst_low = 0; fail_low = 0; lk0 = 0; loss_v = 2'bxx;
      for (int n = 21; n <= 60; n++) begin
         tick();
         if (bus_nr.pll_fail[0] === 1'b1 && f_fail < 0) begin f_fail = n; loss_v = bus_nr.loss_cnt[1:0]; end
         if (n >= 23 && bus_nr.pll_rst[0] !== 1'b1) rst_low++;
         if (n >= 23 && bus_nr.pll_fail[0] !== 1'b1) fail_low++;
         if (n >= 23 && bus_nr.pll_locked[0] === 1'b1) lk0++;
         if (n == 25) bus_nr.pll_lock[0] = 1'b1;
      end
      total++; if (f_fail != 23) $display("FAIL nr_fail_cycle: got %0d want 23", f_fail); else passed++;
      total++; if (loss_v !== 2'd1) $display("FAIL nr_loss_at_fail: got %0d want 1", loss_v); else passed++;
      total++; if (rst_low != 0) $display("FAIL nr_no_retry: got %0d rst-low cycles want 0", rst_low); else passed++;
      total++; if (fail_low != 0) $display("FAIL nr_fail_sticky: got %0d fail-low cycles want 0", fail_low); else passed++;
      total++; if (lk0 != 0) $display("FAIL nr_no_relock: got %0d locked cycles want 0", lk0); else passed++;
      total++; if (bus_nr.loss_cnt[1:0] !== 2'd1) $display("FAIL nr_loss_final: got %0d want 1", bus_nr.loss_cnt[1:0]); else passed++;
      total++; if (bus_nr.pll_locked[1] !== 1'b1) $display("FAIL nr_ch1_locked: got %b want 1", bus_nr.pll_locked[1]); else passed++;
      bus_nr.clr = 1'b1;
      tick();
      bus_nr.clr = 1'b0;
      total++; if (bus_nr.pll_fail !== 2'b00) $display("FAIL nr_clr_fail: got %b want 00", bus_nr.pll_fail); else passed++;
      total++; if (bus_nr.pll_rst !== 2'b11) $display("FAIL nr_clr_rst: got %b want 11", bus_nr.pll_rst); else passed++;
   endtask

   initial begin
      total  = 0;
      passed = 0;
      test_reset();
      test_nominal();
      test_lock_loss();
      test_chatter();
      test_clr();
      test_reset_mid();
      test_no_relock();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
